// File: rtl/instr_queue.sv
// instr_queue: four-entry fetch-to-decode instruction queue with branch flush
module instr_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [ADDR_W-1:0]          in_pc_plus1,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc_plus1,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + ADDR_W;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = (count_q != '0) && !flush;
  assign {out_instr, out_pc_plus1} = mem_q[rd_ptr_q];
  assign count = count_q;
  // next state: flush empties the queue and blocks both push and pop
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_instr, in_pc_plus1};
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // state registers; reset also zeroes storage so outputs read 0 afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue
module tb_instr_queue;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_instr = 0, in_pc_plus1 = 0, out_instr, out_pc_plus1;
  logic [2:0] count;
  int checks = 0, errors = 0;

  instr_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc_plus1(in_pc_plus1), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus1(out_pc_plus1), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] p);
    in_valid = 1; in_instr = w; in_pc_plus1 = p;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1; in_valid = 1; in_instr = 16'hdead; in_pc_plus1 = 16'hbeef;
    tick(); tick();
    reset = 0; in_valid = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_instr !== 16'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0000", out_instr); end
    checks++; if (out_pc_plus1 !== 16'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0000", out_pc_plus1); end
  endtask

  task automatic test_fill;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, in_ready); end
      push(16'h1001 + 16'(i), 16'h0001 + 16'(i));
    end
    in_valid = 1; in_instr = 16'h1005; in_pc_plus1 = 16'h0005;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", in_ready); end
    out_ready = 1;
    #1;
    checks++; if (out_instr !== 16'h1001) begin errors++; $display("FAIL fill_head got %h exp 1001", out_instr); end
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_after_pop_count got %0d exp 3", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_reopen_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_held_accept got %0d exp 4", count); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_instr !== 16'h1002 + 16'(i) || out_pc_plus1 !== 16'h0002 + 16'(i) || out_valid !== 1'b1)
        begin errors++; $display("FAIL fill_drain_%0d got %h/%h v%b exp %h/%h v1", i, out_instr, out_pc_plus1, out_valid, 16'h1002 + 16'(i), 16'h0002 + 16'(i)); end
      tick();
    end
    out_ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", count); end
  endtask

  task automatic test_stream;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_instr = 16'h2000 + 16'(i); in_pc_plus1 = 16'h0010 + 16'(i);
      #1;
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_instr !== 16'h2000 + 16'(i - 1) || out_pc_plus1 !== 16'h0010 + 16'(i - 1))
          begin errors++; $display("FAIL stream_%0d got %h/%h v%b exp %h/%h v1", i, out_instr, out_pc_plus1, out_valid, 16'h2000 + 16'(i - 1), 16'h0010 + 16'(i - 1)); end
      end
      checks++; if (count !== ((i > 0) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL stream_count_%0d got %0d exp %0d", i, count, (i > 0) ? 1 : 0); end
      tick();
    end
    in_valid = 0;
    #1;
    checks++; if (out_instr !== 16'h2009 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_last got %h v%b exp 2009 v1", out_instr, out_valid); end
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_empty got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back;
    out_ready = 0;
    push(16'h5000, 16'h0050);
    push(16'h5001, 16'h0051);
    out_ready = 1; in_valid = 1; in_instr = 16'h5002; in_pc_plus1 = 16'h0052;
    #1;
    checks++; if (out_instr !== 16'h5000) begin errors++; $display("FAIL b2b_head0 got %h exp 5000", out_instr); end
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
    checks++; if (out_instr !== 16'h5001) begin errors++; $display("FAIL b2b_head1 got %h exp 5001", out_instr); end
    tick();
    checks++; if (out_instr !== 16'h5002 || out_pc_plus1 !== 16'h0052) begin errors++; $display("FAIL b2b_head2 got %h/%h exp 5002/0052", out_instr, out_pc_plus1); end
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count); end
  endtask

  task automatic test_flush;
    out_ready = 0;
    for (int i = 0; i < 3; i++) push(16'h3000 + 16'(i), 16'h0030 + 16'(i));
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1; out_ready = 1; in_valid = 1; in_instr = 16'h3003; in_pc_plus1 = 16'h0033;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got count %0d v%b exp 0 v0", count, out_valid); end
    push(16'h4000, 16'h0040);
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'h4000 || out_pc_plus1 !== 16'h0040 || count !== 3'd1)
      begin errors++; $display("FAIL flush_post_push got %h/%h v%b c%0d exp 4000/0040 v1 c1", out_instr, out_pc_plus1, out_valid, count); end
    push(16'h4001, 16'h0041);
    flush = 1; in_valid = 1; in_instr = 16'h4444; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_multi_%0d got c%0d v%b exp c0 v0", i, count, out_valid); end
    end
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_multi_end got c%0d v%b exp c0 v0", count, out_valid); end
  endtask

  task automatic test_stall;
    out_ready = 0;
    push(16'h6000, 16'h0060);
    push(16'h6001, 16'h0061);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_instr !== 16'h6000 || out_pc_plus1 !== 16'h0060 || out_valid !== 1'b1 || count !== 3'd2)
        begin errors++; $display("FAIL stall_%0d got %h/%h v%b c%0d exp 6000/0060 v1 c2", i, out_instr, out_pc_plus1, out_valid, count); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    push(16'h7000, 16'h0070);
    reset = 1;
    tick();
    reset = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got c%0d v%b r%b exp c0 v0 r1", count, out_valid, in_ready); end
    checks++; if (out_instr !== 16'h0 || out_pc_plus1 !== 16'h0) begin errors++; $display("FAIL rstmid_data got %h/%h exp 0000/0000", out_instr, out_pc_plus1); end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill();
    test_stream();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
# instr_queue

Four-entry instruction queue between the fetch stage and decode. Each cycle it accepts one instruction word, with the PC+1 value that accompanies it, from fetch under a valid/ready handshake. It presents entries to decode in program order under a second valid/ready handshake. A branch-taken flush discards all buffered entries; backpressure to fetch is the signal that holds the program counter.

## Interface
Parameters:
- `DATA_W`, 16, instruction word width
- `ADDR_W`, 16, PC+1 width
- `DEPTH`, 4, number of entries; must be a power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `in_valid`  in  1  fetch presents a word this cycle
- `in_ready`  out  1  queue can accept; fetch holds the PC while low
- `in_instr`  in  DATA_W  instruction word from instruction ROM
- `in_pc_plus1`  in  ADDR_W  PC+1 of that instruction, from the fetch adder
- `flush`  in  1  branch taken (pcSrc asserted); discard all contents
- `out_valid`  out  1  head entry available to decode
- `out_ready`  in  1  decode consumes the head this cycle
- `out_instr`  out  DATA_W  head instruction word
- `out_pc_plus1`  out  ADDR_W  head PC+1
- `count`  out  log2(DEPTH)+1  number of occupied entries, 0..DEPTH

## Operation
- State: circular storage `DEPTH` × (DATA_W+ADDR_W), `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each, `count` register.
- Push = `in_valid && in_ready && !flush`. Writes {`in_instr`, `in_pc_plus1`} at `wr_ptr`, then `wr_ptr` increments.
- Pop = `out_valid && out_ready`. `rd_ptr` increments.
- Pointers wrap modulo DEPTH with natural binary rollover (3 → 0 for DEPTH = 4).
- `count` next value:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together
- `in_ready` = (`count` != DEPTH). It depends only on registered state; there is no combinational path from `out_ready`. When full, a simultaneous pop does not open a slot that same cycle.
- `out_valid` = (`count` != 0) && !`flush`.
- `out_instr`/`out_pc_plus1` = storage[`rd_ptr`], combinational from registered state. Values are stable while `out_valid && !out_ready`.
- Flush has priority over everything:
  - next cycle `count` = 0 and `wr_ptr` = `rd_ptr` = 0
  - any push offered in the flush cycle is dropped
  - no pop occurs in the flush cycle
  - storage contents are not cleared
- Reset (sync) clears pointers, `count`, and all storage to 0. After reset: `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_instr` = 0, `out_pc_plus1` = 0.
- Reset has priority over flush. Reset mid-stream discards all entries identically to flush and also zeroes storage.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge N is visible with `out_valid` = 1 after edge N. There is no same-cycle bypass from `in_*` to `out_*`.
- Throughput is 1 word/cycle sustained whenever 0 < `count` < DEPTH with both sides active.
- Full (`count` = DEPTH): `in_ready` = 0. Fetch must hold `in_instr`/`in_pc_plus1` and its PC until `in_ready` returns to 1, which is the cycle after the first pop.
- Empty (`count` = 0): `out_valid` = 0. `out_ready` is ignored and the pointers do not move.
- Flush asserted at edge N: `out_valid` is 0 during the flush cycle and after edge N. The first post-flush word pushed at edge N+1 is visible after edge N+1.
- Multi-cycle flush: the queue stays empty and rejects pushes for every cycle `flush` is high.
- `count` is registered and reflects the state after the most recent edge.

## Test plan
- Reset then idle:
  - assert `reset` 2 cycles with `in_valid` = 1 → `count` = 0, `out_valid` = 0, `in_ready` = 1, outputs 0
  - no entry is captured during reset
- Fill to full:
  - push 0x1001..0x1005 (PC+1 0x0001..0x0005) on consecutive cycles with `out_ready` = 0
  - → first four accepted, `count` = 4, `in_ready` = 0 on cycle 5
  - 0x1005 is held by fetch and accepted the cycle after one pop
- Streaming with wrap:
  - push 10 words 0x2000..0x2009 with `out_ready` = 1 every cycle
  - → decode receives all 10 in order, each one cycle after its push
  - `count` stays at 1 in steady state
  - pointers wrap twice without loss
- Simultaneous push and pop at `count` = 2 → `count` stays 2 and the head advances to the next word in order.
- Flush mid-stream:
  - with `count` = 3 (0x3000..0x3002), assert `flush` while offering 0x3003 and `out_ready` = 1
  - → `out_valid` = 0 that cycle; 0x3003 is dropped and no pop occurs
  - next cycle `count` = 0; push 0x4000 is visible one cycle later
- Decode stall stability: hold `out_ready` = 0 for 5 cycles with `count` = 2 → `out_instr`/`out_pc_plus1` are unchanged every cycle.
